// File: rtl/microseq_ctrl.sv
// Microsequencer controller: decodes the next-address field of the current
// microinstruction and issues a NONE/INC/LOAD command (plus load address) to
// the 11-bit microaddress counter. Supports conditional branches, opcode
// dispatch, wait-on-condition, halt/restart and a hardware return stack.
//
// Handshake: cmd/load_addr are valid every cycle that reset_n is high; the
// counter acts on them at the next posedge. stall plays the role of a
// "not ready" from the datapath and freezes sequencing (cmd=NONE, no stack or
// state change) while the controller is in RUN.

package microaddr;
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INC  = 2'd1,
    CMD_LOAD = 2'd2
  } cmd_t;
endpackage

module microseq_ctrl #(
  parameter int          STACK_DEPTH = 4,
  parameter logic [10:0] RESET_VEC   = 11'h000,
  localparam int         DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      addr,
  input  logic [2:0]       seq_op,
  input  logic [10:0]      seq_target,
  input  logic [2:0]       cond_sel,
  input  logic             cond_inv,
  input  logic [7:0]       flags,
  input  logic [10:0]      dispatch_addr,
  input  logic             stall,
  input  logic             start,
  output microaddr::cmd_t  cmd,
  output logic [10:0]      load_addr,
  output logic [DW-1:0]    depth,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_JUMP_IF  = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_DISPATCH = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;
  localparam logic [2:0] OP_HALT     = 3'd7;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q;
  // Sized to the full index range so depth_q can address it directly; only
  // the first STACK_DEPTH entries are ever written.
  logic [10:0]     stack_mem [2**DW];
  logic            push, pop;
  logic            cond;
  logic            stack_full, stack_empty;
  logic [10:0]     ret_addr;
  logic [10:0]     tos;

  assign cond        = flags[cond_sel] ^ cond_inv;
  assign stack_full  = (depth_q == DW'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  assign ret_addr    = addr + 11'd1;
  assign tos         = stack_mem[depth_q - DW'(1)];

  // State register: async reset returns to BOOT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // Next-state logic; stall only freezes RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (seq_op == OP_HALT)                      state_d = ST_HALT;
          else if (seq_op == OP_CALL && stack_full)   state_d = ST_FAULT;
          else if (seq_op == OP_RET  && stack_empty)  state_d = ST_FAULT;
        end
      end
      ST_HALT:  if (start) state_d = ST_RUN;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Output decode: counter command, load address and stack push/pop strobes.
  always_comb begin
    cmd       = microaddr::CMD_NONE;
    load_addr = 11'h000;
    push      = 1'b0;
    pop       = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_BOOT: begin
          cmd       = microaddr::CMD_LOAD;
          load_addr = RESET_VEC;
        end
        ST_RUN: begin
          if (!stall) begin
            unique case (seq_op)
              OP_NEXT: cmd = microaddr::CMD_INC;
              OP_JUMP: begin
                cmd       = microaddr::CMD_LOAD;
                load_addr = seq_target;
              end
              OP_JUMP_IF: begin
                if (cond) begin
                  cmd       = microaddr::CMD_LOAD;
                  load_addr = seq_target;
                end else begin
                  cmd = microaddr::CMD_INC;
                end
              end
              OP_CALL: begin
                if (!stack_full) begin
                  cmd       = microaddr::CMD_LOAD;
                  load_addr = seq_target;
                  push      = 1'b1;
                end
              end
              OP_RET: begin
                if (!stack_empty) begin
                  cmd       = microaddr::CMD_LOAD;
                  load_addr = tos;
                  pop       = 1'b1;
                end
              end
              OP_DISPATCH: begin
                cmd       = microaddr::CMD_LOAD;
                load_addr = dispatch_addr;
              end
              OP_WAIT: if (cond) cmd = microaddr::CMD_INC;
              OP_HALT: cmd = microaddr::CMD_NONE;
              default: cmd = microaddr::CMD_NONE;
            endcase
          end
        end
        ST_HALT: begin
          if (start) begin
            cmd       = microaddr::CMD_LOAD;
            load_addr = RESET_VEC;
          end
        end
        ST_FAULT: cmd = microaddr::CMD_NONE;
        default:  cmd = microaddr::CMD_NONE;
      endcase
    end
  end

  // Stack occupancy: reset discards all entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  depth_q <= '0;
    else if (push) depth_q <= depth_q + DW'(1);
    else if (pop)  depth_q <= depth_q - DW'(1);
  end

  // Return-address storage; contents are meaningless once depth is cleared.
  always_ff @(posedge clk) begin
    if (push) stack_mem[depth_q] <= ret_addr;
  end

  assign depth     = depth_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Testbench for microseq_ctrl: directed scenarios plus randomized traffic,
// checked against a queue-based reference model through an expected queue.

module tb_microseq_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [10:0] RV    = 11'h000;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_INC  = 2'd1;
  localparam logic [1:0] C_LOAD = 2'd2;

  // clock / reset and DUT signals
  logic             clk = 1'b0;
  logic             reset_n;
  logic [10:0]      addr, seq_target, dispatch_addr;
  logic [2:0]       seq_op, cond_sel;
  logic             cond_inv, stall, start;
  logic [7:0]       flags;
  microaddr::cmd_t  cmd;
  logic [10:0]      load_addr;
  logic [2:0]       depth;
  logic             halted, fault;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  microseq_ctrl #(.STACK_DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .seq_op(seq_op),
    .seq_target(seq_target), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .flags(flags), .dispatch_addr(dispatch_addr), .stall(stall),
    .start(start), .cmd(cmd), .load_addr(load_addr), .depth(depth),
    .halted(halted), .fault(fault), .dbg_state(dbg_state)
  );

  // scoreboard: {cmd, load_addr, depth(4), halted, fault}
  logic [18:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // reference model
  int          mode;
  logic [10:0] stk[$];

  task automatic model_reset();
    mode = M_BOOT;
    stk.delete();
    exp_q.push_back({C_NONE, 11'h000, 4'd0, 1'b0, 1'b0});
  endtask

  task automatic model_step();
    logic [1:0]  c;
    logic [10:0] la;
    int          nmode;
    logic        cnd;
    logic        do_push, do_pop;
    c = C_NONE; la = 11'h000; nmode = mode; do_push = 1'b0; do_pop = 1'b0;
    cnd = flags[cond_sel] ^ cond_inv;
    case (mode)
      M_BOOT: begin c = C_LOAD; la = RV; nmode = M_RUN; end
      M_RUN: if (!stall) begin
        case (seq_op)
          3'd0: c = C_INC;
          3'd1: begin c = C_LOAD; la = seq_target; end
          3'd2: if (cnd) begin c = C_LOAD; la = seq_target; end else c = C_INC;
          3'd3: if (stk.size() == DEPTH) nmode = M_FAULT;
                else begin c = C_LOAD; la = seq_target; do_push = 1'b1; end
          3'd4: if (stk.size() == 0) nmode = M_FAULT;
                else begin c = C_LOAD; la = stk[$]; do_pop = 1'b1; end
          3'd5: begin c = C_LOAD; la = dispatch_addr; end
          3'd6: c = cnd ? C_INC : C_NONE;
          default: nmode = M_HALT;
        endcase
      end
      M_HALT: if (start) begin c = C_LOAD; la = RV; nmode = M_RUN; end
      default: ;
    endcase
    exp_q.push_back({c, la, 4'(stk.size()), 1'(mode == M_HALT), 1'(mode == M_FAULT)});
    if (do_push) stk.push_back((addr == 11'h7FF) ? 11'h000 : addr + 11'd1);
    if (do_pop)  void'(stk.pop_back());
    mode = nmode;
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] op, input logic [10:0] tgt,
                       input logic [2:0] cs, input logic ci, input logic [7:0] fl,
                       input logic [10:0] da, input logic stl, input logic st,
                       input logic [10:0] a);
    @(posedge clk); #1;
    seq_op = op; seq_target = tgt; cond_sel = cs; cond_inv = ci; flags = fl;
    dispatch_addr = da; stall = stl; start = st; addr = a;
    model_step();
  endtask

  task automatic op_simple(input logic [2:0] op, input logic [10:0] tgt, input logic [10:0] a);
    drive(op, tgt, 3'd0, 1'b0, 8'h00, 11'h055, 1'b0, 1'b0, a);
  endtask

  // async assert at posedge+1, checked at the following negedge (no edge in between)
  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    seq_op = 3'd0; stall = 1'b1; start = 1'b0;
    model_step();
  endtask

  // monitor: compare DUT outputs against expected queue
  initial begin
    logic [18:0] act, ex;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        act = {2'(cmd), load_addr, 1'b0, depth, halted, fault};
        vectors++;
        if (act !== ex) begin
          miscompares++;
          $display("FAIL vec%0d: got cmd=%0d load_addr=%h depth=%0d halted=%b fault=%b, expected cmd=%0d load_addr=%h depth=%0d halted=%b fault=%b",
                   vectors, act[18:17], act[16:6], act[5:2], act[1], act[0],
                   ex[18:17], ex[16:6], ex[5:2], ex[1], ex[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset_n = 1'b0; addr = 11'h000; seq_op = 3'd0; seq_target = 11'h000;
    cond_sel = 3'd0; cond_inv = 1'b0; flags = 8'h00; dispatch_addr = 11'h000;
    stall = 1'b0; start = 1'b0;
    mode = M_BOOT;
    @(posedge clk); #1; model_reset();
    @(posedge clk); #1; model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1; stall = 1'b1;
    model_step();                                   // BOOT, stall ignored
    op_simple(3'd0, 11'h000, 11'h000);              // NEXT -> INC

    // JUMP_IF on flags[2]
    drive(3'd2, 11'h123, 3'd2, 1'b0, 8'h04, 11'h000, 1'b0, 1'b0, 11'h001);
    drive(3'd2, 11'h123, 3'd2, 1'b1, 8'h04, 11'h000, 1'b0, 1'b0, 11'h123);
    op_simple(3'd1, 11'h010, 11'h124);              // JUMP
    op_simple(3'd5, 11'h000, 11'h010);              // DISPATCH

    // nested calls and returns
    op_simple(3'd3, 11'h200, 11'h010);
    op_simple(3'd3, 11'h300, 11'h205);
    op_simple(3'd0, 11'h000, 11'h300);              // depth 2 observed
    op_simple(3'd4, 11'h000, 11'h301);              // -> 0x206
    op_simple(3'd4, 11'h000, 11'h206);              // -> 0x011
    op_simple(3'd3, 11'h400, 11'h7FF);              // pushes 0x000
    op_simple(3'd4, 11'h000, 11'h400);              // -> 0x000
    op_simple(3'd0, 11'h000, 11'h7FF);              // INC at 2047

    // WAIT on flags[0] with stall toggling
    for (int i = 0; i < 16; i++)
      drive(3'd6, 11'h000, 3'd0, 1'b0, 8'($urandom_range(0, 255)), 11'h000,
            1'($urandom_range(0, 1)), 1'b0, 11'h050);
    drive(3'd6, 11'h000, 3'd0, 1'b0, 8'h01, 11'h000, 1'b1, 1'b0, 11'h050);
    drive(3'd6, 11'h000, 3'd0, 1'b0, 8'h01, 11'h000, 1'b0, 1'b0, 11'h050);

    // halt and restart (start with stall still restarts)
    op_simple(3'd3, 11'h600, 11'h020);              // keep one entry to check preservation
    op_simple(3'd7, 11'h000, 11'h600);
    op_simple(3'd1, 11'h111, 11'h601);              // ignored in HALT
    drive(3'd0, 11'h000, 3'd0, 1'b0, 8'h00, 11'h000, 1'b1, 1'b1, 11'h601);
    op_simple(3'd4, 11'h000, 11'h000);              // stack preserved -> 0x021

    // overflow
    for (int i = 0; i < 5; i++) op_simple(3'd3, 11'(12'h100 + i), 11'(12'h080 + i));
    op_simple(3'd0, 11'h000, 11'h000);
    drive(3'd0, 11'h000, 3'd0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b1, 11'h000);
    do_reset();

    // underflow
    op_simple(3'd4, 11'h000, 11'h000);
    op_simple(3'd0, 11'h000, 11'h000);
    do_reset();

    // reset mid-call chain
    for (int i = 0; i < 3; i++) op_simple(3'd3, 11'(12'h700 + i), 11'(12'h0A0 + i));
    do_reset();
    op_simple(3'd0, 11'h000, 11'h000);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (mode == M_FAULT && $urandom_range(0, 3) == 0) do_reset();
      else
        drive(3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 11'($urandom_range(0, 2047)),
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
              11'($urandom_range(0, 2047)));
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
